// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default operand width and opcode encodings.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_RAND = 3'b011;
    localparam logic [2:0] OP_RSVD = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and whatever drives it.
// The master side supplies operands and opcode; the slave side (the ALU) returns
// the registered result and its flags.
interface alu_if import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [2:0]         opcode;
    logic [2*WIDTH-1:0] out;
    logic               Sign_Flag;
    logic               Zero_Flag;

    modport master (
        output A, B, opcode,
        input  out, Sign_Flag, Zero_Flag
    );

    modport slave (
        input  A, B, opcode,
        output out, Sign_Flag, Zero_Flag
    );

endinterface

// File: rtl/alu_datapath.sv
// Purely combinational ALU datapath. Operands are zero-extended to double width
// so that carries, borrows, full products and left-shifted bits all land in the
// upper half instead of being lost.
module alu_datapath import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         opcode,
    output logic [2*WIDTH-1:0] result
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [4:0]    shamt;

    assign a_ext = {{WIDTH{1'b0}}, A};
    assign b_ext = {{WIDTH{1'b0}}, B};
    assign shamt = B[4:0];

    // Select the operation result; anything unrecognised yields zero.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a_ext + b_ext;
            OP_SUB:  result = a_ext - b_ext;
            OP_MUL:  result = a_ext * b_ext;
            OP_RAND: result = {{(RW-1){1'b0}}, &A};
            OP_RSVD: result = '0;
            OP_XOR:  result = {{WIDTH{1'b0}}, A ^ B};
            OP_SHL:  result = a_ext << shamt;
            OP_SHR:  result = {{WIDTH{1'b0}}, A >> shamt};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top level. The datapath result is captured every cycle and
// both flags are computed from that same next value, so out and the flags can
// never disagree within a cycle.
module alu import alu_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [2*WIDTH-1:0] result;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .A      (bus.A),
        .B      (bus.B),
        .opcode (bus.opcode),
        .result (result)
    );

    // Result and flag registers; reset forces a zero result with the zero flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out       <= '0;
            bus.Sign_Flag <= 1'b0;
            bus.Zero_Flag <= 1'b1;
        end else begin
            bus.out       <= result;
            bus.Sign_Flag <= result[2*WIDTH-1];
            bus.Zero_Flag <= (result == '0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for the ALU: directed corner cases followed by random
// vectors compared against an arithmetic reference model.
module tb_alu;

    logic clk;
    logic rst;

    int assert_count;
    int fail_count;

    alu_if #(.WIDTH(32)) bus_if ();

    alu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected result from the operation definitions using plain integer arithmetic.
    function automatic logic [63:0] refModel(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  op);
        longint unsigned x;
        longint unsigned y;
        longint unsigned pow2;
        logic [31:0]     xr;
        x    = {32'b0, a};
        y    = {32'b0, b};
        pow2 = 1;
        for (int i = 0; i < (b % 32); i++) pow2 = pow2 * 2;
        xr = a ^ b;
        case (op)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x * y;
            3'd3:    return (a == 32'hFFFF_FFFF) ? 64'd1 : 64'd0;
            3'd4:    return 64'd0;
            3'd5:    return {32'b0, xr};
            3'd6:    return x * pow2;
            3'd7:    return x / pow2;
            default: return 64'd0;
        endcase
    endfunction

    // Drive one operand set while keeping the reset level requested.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input logic rst_val);
        bus_if.A      = a;
        bus_if.B      = b;
        bus_if.opcode = op;
        rst           = rst_val;
        @(posedge clk);
        #1;
    endtask

    // Compare result and both flags against the expected result value.
    task automatic checkOutput(input string tag, input logic [63:0] exp_out);
        logic exp_sign;
        logic exp_zero;
        exp_sign = exp_out[63];
        exp_zero = (exp_out == 64'd0);
        assert_count++;
        assert (bus_if.out === exp_out) else begin
            fail_count++;
            $error("[TB] FAIL %s out: got %h expected %h", tag, bus_if.out, exp_out);
        end
        assert_count++;
        assert (bus_if.Sign_Flag === exp_sign) else begin
            fail_count++;
            $error("[TB] FAIL %s Sign_Flag: got %b expected %b", tag, bus_if.Sign_Flag, exp_sign);
        end
        assert_count++;
        assert (bus_if.Zero_Flag === exp_zero) else begin
            fail_count++;
            $error("[TB] FAIL %s Zero_Flag: got %b expected %b", tag, bus_if.Zero_Flag, exp_zero);
        end
    endtask

    // Directed sequence, then random vectors, then the summary.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;
        assert_count  = 0;
        fail_count    = 0;
        rst           = 1'b1;
        bus_if.A      = 32'd0;
        bus_if.B      = 32'd0;
        bus_if.opcode = 3'd0;

        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 3'd2, 1'b1);
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 3'd2, 1'b1);
        checkOutput("reset", 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'd1, 3'd0, 1'b0);
        checkOutput("add_carry", 64'h1_0000_0000);

        applyStimulus(32'd1, 32'd2, 3'd1, 1'b0);
        checkOutput("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(32'd5, 32'd5, 3'd1, 1'b0);
        checkOutput("sub_zero", 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0);
        checkOutput("mul_max", 64'hFFFF_FFFE_0000_0001);

        applyStimulus(32'hFFFF_FFFF, 32'h1234_0000, 3'd3, 1'b0);
        checkOutput("rand_ones", 64'd1);

        applyStimulus(32'hFFFF_FFFE, 32'hFFFF_FFFF, 3'd3, 1'b0);
        checkOutput("rand_notall", 64'd0);

        applyStimulus(32'hF0F0_F0F0, 32'hFFFF_0000, 3'd5, 1'b0);
        checkOutput("xor", 64'h0F0F_F0F0);

        applyStimulus(32'h8000_0001, 32'h0000_0021, 3'd6, 1'b0);
        checkOutput("shl_1", 64'h1_0000_0002);

        applyStimulus(32'h8000_0000, 32'd31, 3'd7, 1'b0);
        checkOutput("shr_31", 64'd1);

        applyStimulus(32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'd6, 1'b0);
        checkOutput("shl_0", 64'h0000_0000_DEAD_BEEF);

        applyStimulus(32'hCAFE_F00D, 32'h0000_0040, 3'd7, 1'b0);
        checkOutput("shr_0", 64'h0000_0000_CAFE_F00D);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd4, 1'b0);
        checkOutput("reserved", 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b1);
        checkOutput("reset_mul", 64'd0);

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0);
        checkOutput("post_reset_mul", 64'hFFFF_FFFE_0000_0001);

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 3'($urandom_range(7, 0));
            if (i % 8 == 0) rb = rb & 32'h0000_001F;
            applyStimulus(ra, rb, rop, 1'b0);
            checkOutput($sformatf("rand%0d_op%0d", i, rop), refModel(ra, rb, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 32, operand width; result width is 2*WIDTH (64 at default).
REQ-002 clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 A  input  WIDTH  first operand, unsigned.
REQ-005 B  input  WIDTH  second operand, unsigned; B[4:0] is the shift amount.
REQ-006 opcode  input  3  operation select.
REQ-007 out  output  2*WIDTH  registered result.
REQ-008 Sign_Flag  output  1  registered copy of out[MSB].
REQ-009 Zero_Flag  output  1  registered, high when out is all zeros.

Function
REQ-010 A, B and opcode SHALL be sampled on every rising clk edge with rst low; out, Sign_Flag and Zero_Flag SHALL update on that same edge (1-cycle latency, no handshake, one new result per cycle).
REQ-011 Every operation SHALL zero-extend A and B to 2*WIDTH before computing, with the result truncated to 2*WIDTH.
REQ-012 opcode 000: out = A + B; the carry is kept in bit WIDTH.
REQ-013 opcode 001: out = A - B modulo 2^(2*WIDTH); A < B yields upper bits all ones (e.g. 1 - 2 = 64'hFFFF_FFFF_FFFF_FFFF).
REQ-014 opcode 010: out = full unsigned product A * B (2*WIDTH bits, no truncation).
REQ-015 opcode 011: out[0] = reduction AND of A; all other bits of out are 0; B is ignored.
REQ-016 opcode 100: out = 0 (reserved).
REQ-017 opcode 101: out[WIDTH-1:0] = A ^ B; upper WIDTH bits are 0.
REQ-018 opcode 110: out = zero-extended A shifted left by B[4:0]; bits shifted past bit WIDTH-1 are kept in the upper half; B[31:5] is ignored.
REQ-019 opcode 111: out = A logically shifted right by B[4:0], zero fill; upper half is 0.
REQ-020 Sign_Flag SHALL equal out[2*WIDTH-1] in every cycle.
REQ-021 Zero_Flag SHALL equal (out == 0) in every cycle.
REQ-022 The flags SHALL be derived from the same next-state value as out, so no cycle shows a flag and out that disagree.
REQ-023 Shift amount 0 SHALL pass A through unchanged.
REQ-024 X/Z on opcode is not defined; the result for any opcode value outside 000-111 SHALL be 0.

Reset
REQ-025 When rst is high at a rising edge, out SHALL become 0, Sign_Flag 0 and Zero_Flag 1, overriding any operation in progress.
REQ-026 The first valid result SHALL appear on the first rising edge on which rst is low.

Structure
REQ-027 Shared package alu_pkg SHALL hold the WIDTH default and localparams for the opcodes: OP_ADD=000, OP_SUB=001, OP_MUL=010, OP_RAND=011, OP_RSVD=100, OP_XOR=101, OP_SHL=110, OP_SHR=111.
REQ-028 The combinational datapath SHALL be one sub-module, alu_datapath, with inputs A/B/opcode and output result; alu SHALL register result and derive both flags from it.
REQ-029 The design SHALL contain no latches, and every case statement SHALL have a default branch that yields 0.

Verification
REQ-030 ADD: A=32'hFFFF_FFFF, B=1, opcode 000 -> after one edge out=64'h1_0000_0000, Sign_Flag=0, Zero_Flag=0.
REQ-031 SUB: A=1, B=2, opcode 001 -> out=64'hFFFF_FFFF_FFFF_FFFF, Sign_Flag=1, Zero_Flag=0. Also A=5, B=5 -> out=0, Zero_Flag=1.
REQ-032 MUL: A=B=32'hFFFF_FFFF, opcode 010 -> out=64'hFFFF_FFFE_0000_0001, Sign_Flag=1.
REQ-033 Reduction AND and XOR:
- opcode 011, A=32'hFFFF_FFFF -> out=1.
- opcode 011, A=32'hFFFF_FFFE -> out=0, Zero_Flag=1.
- opcode 101, A=32'hF0F0_F0F0, B=32'hFFFF_0000 -> out=64'h0F0F_F0F0.
REQ-034 Shifts and reserved opcode:
- opcode 110, A=32'h8000_0001, B=32'h0000_0021 (shift 1) -> out=64'h1_0000_0002.
- opcode 111, A=32'h8000_0000, B=31 -> out=1.
- opcode 100, any A/B -> out=0, Zero_Flag=1.
REQ-035 Reset and random check:
- rst held high during a MUL -> out=0, Sign_Flag=0, Zero_Flag=1 on that edge.
- 30+ random A/B/opcode vectors, each checked one cycle later against REQ-012..REQ-021.
